// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: Tuse/Tnew stall detection,
// forwarding-mux selects for D/E/M, and the HI/LO multiply/divide busy stall.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [1:0] TnewD,
    input  logic [4:0] A_rsD,
    input  logic [4:0] A_rtD,
    input  logic [4:0] AwriteD,
    input  logic       md_useD,
    input  logic       md_startE,
    input  logic       md_divE,
    output logic       stall,
    output logic       md_busy,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM
);

    // E/M/W tracking entries; W.Tnew is always 0 so it is not stored.
    logic [4:0] r_e_aw;
    logic [1:0] r_e_tnew;
    logic [4:0] r_e_ars;
    logic [4:0] r_e_art;
    logic [4:0] r_m_aw;
    logic [1:0] r_m_tnew;
    logic [4:0] r_m_art;
    logic [4:0] r_w_aw;
    logic [3:0] r_md_cnt;

    logic w_hit_rs_e, w_hit_rs_m, w_hit_rt_e, w_hit_rt_m;
    logic w_stall_md, w_stall, w_md_busy;

    function automatic logic [1:0] dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    function automatic logic hit(input logic [4:0] a, input logic [1:0] tuse,
                                 input logic [4:0] s_aw, input logic [1:0] s_tnew);
        return (a != 5'd0) && (a == s_aw) && (tuse != 2'd3) && (tuse < s_tnew);
    endfunction

    // M wins over W, and only once its result is ready (Tnew == 0).
    function automatic logic [1:0] fwd_sel(input logic [4:0] a, input logic [4:0] m_aw,
                                           input logic [1:0] m_tnew, input logic [4:0] w_aw);
        if (a == 5'd0)
            return 2'd0;
        else if (a == m_aw && m_tnew == 2'd0)
            return 2'd1;
        else if (a == w_aw)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign w_hit_rs_e = hit(A_rsD, Tuse_rs, r_e_aw, r_e_tnew);
    assign w_hit_rs_m = hit(A_rsD, Tuse_rs, r_m_aw, r_m_tnew);
    assign w_hit_rt_e = hit(A_rtD, Tuse_rt, r_e_aw, r_e_tnew);
    assign w_hit_rt_m = hit(A_rtD, Tuse_rt, r_m_aw, r_m_tnew);

    assign w_md_busy  = md_startE | (r_md_cnt != 4'd0);
    assign w_stall_md = md_useD & w_md_busy;
    assign w_stall    = w_hit_rs_e | w_hit_rs_m | w_hit_rt_e | w_hit_rt_m | w_stall_md;

    assign stall   = w_stall;
    assign md_busy = w_md_busy;
    assign fwd_rsD = fwd_sel(A_rsD,   r_m_aw, r_m_tnew, r_w_aw);
    assign fwd_rtD = fwd_sel(A_rtD,   r_m_aw, r_m_tnew, r_w_aw);
    assign fwd_rsE = fwd_sel(r_e_ars, r_m_aw, r_m_tnew, r_w_aw);
    assign fwd_rtE = fwd_sel(r_e_art, r_m_aw, r_m_tnew, r_w_aw);
    assign fwd_rtM = (r_m_art != 5'd0) && (r_m_art == r_w_aw);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_aw   <= '0;
            r_e_tnew <= '0;
            r_e_ars  <= '0;
            r_e_art  <= '0;
            r_m_aw   <= '0;
            r_m_tnew <= '0;
            r_m_art  <= '0;
            r_w_aw   <= '0;
        end else if (flush) begin
            r_e_aw   <= '0;
            r_e_tnew <= '0;
            r_e_ars  <= '0;
            r_e_art  <= '0;
            r_m_aw   <= '0;
            r_m_tnew <= '0;
            r_m_art  <= '0;
            r_w_aw   <= '0;
        end else begin
            if (w_stall) begin
                r_e_aw   <= '0;
                r_e_tnew <= '0;
                r_e_ars  <= '0;
                r_e_art  <= '0;
            end else begin
                r_e_aw   <= AwriteD;
                r_e_tnew <= dec(TnewD);
                r_e_ars  <= A_rsD;
                r_e_art  <= A_rtD;
            end
            r_m_aw   <= r_e_aw;
            r_m_tnew <= dec(r_e_tnew);
            r_m_art  <= r_e_art;
            r_w_aw   <= r_m_aw;
        end
    end

    // The mult/div unit keeps running across a flush, so only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_md_cnt <= '0;
        else if (md_startE)
            r_md_cnt <= md_divE ? 4'(DIV_CYC) : 4'(MULT_CYC);
        else if (r_md_cnt != 4'd0)
            r_md_cnt <= r_md_cnt - 4'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each check() samples the DUT outputs shortly
// after the stimulus is applied and compares every output field.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [1:0] Tuse_rs, Tuse_rt, TnewD;
  logic [4:0] A_rsD, A_rtD, AwriteD;
  logic       md_useD, md_startE, md_divE;
  logic       stall, md_busy, fwd_rtM;
  logic [1:0] fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .Tuse_rs   (Tuse_rs),
    .Tuse_rt   (Tuse_rt),
    .TnewD     (TnewD),
    .A_rsD     (A_rsD),
    .A_rtD     (A_rtD),
    .AwriteD   (AwriteD),
    .md_useD   (md_useD),
    .md_startE (md_startE),
    .md_divE   (md_divE),
    .stall     (stall),
    .md_busy   (md_busy),
    .fwd_rsD   (fwd_rsD),
    .fwd_rtD   (fwd_rtD),
    .fwd_rsE   (fwd_rsE),
    .fwd_rtE   (fwd_rtE),
    .fwd_rtM   (fwd_rtM)
  );

  always #5 clk = ~clk;

  // Packed order: stall, md_busy, rsD, rtD, rsE, rtE, rtM
  function automatic logic [10:0] ev(input logic s, input logic b, input logic [1:0] rsd,
                                     input logic [1:0] rtd, input logic [1:0] rse,
                                     input logic [1:0] rte, input logic rtm);
    return {s, b, rsd, rtd, rse, rte, rtm};
  endfunction

  task automatic check(input string name, input logic [10:0] v);
    bit bad;
    #1;
    bad = 1'b0;
    n_cmp++;
    if (stall !== v[10]) begin
      bad = 1'b1;
      $display("FAIL %s: stall=%b required %b", name, stall, v[10]);
    end
    if (md_busy !== v[9]) begin
      bad = 1'b1;
      $display("FAIL %s: md_busy=%b required %b", name, md_busy, v[9]);
    end
    if (fwd_rsD !== v[8:7]) begin
      bad = 1'b1;
      $display("FAIL %s: fwd_rsD=%0d required %0d", name, fwd_rsD, v[8:7]);
    end
    if (fwd_rtD !== v[6:5]) begin
      bad = 1'b1;
      $display("FAIL %s: fwd_rtD=%0d required %0d", name, fwd_rtD, v[6:5]);
    end
    if (fwd_rsE !== v[4:3]) begin
      bad = 1'b1;
      $display("FAIL %s: fwd_rsE=%0d required %0d", name, fwd_rsE, v[4:3]);
    end
    if (fwd_rtE !== v[2:1]) begin
      bad = 1'b1;
      $display("FAIL %s: fwd_rtE=%0d required %0d", name, fwd_rtE, v[2:1]);
    end
    if (fwd_rtM !== v[0]) begin
      bad = 1'b1;
      $display("FAIL %s: fwd_rtM=%b required %b", name, fwd_rtM, v[0]);
    end
    if (bad) n_err++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] aw, input logic [1:0] tn,
                       input logic [4:0] rs, input logic [1:0] urs,
                       input logic [4:0] rt, input logic [1:0] urt);
    AwriteD = aw;
    TnewD   = tn;
    A_rsD   = rs;
    Tuse_rs = urs;
    A_rtD   = rt;
    Tuse_rt = urt;
  endtask

  task automatic idle();
    set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    flush     = 1'b0;
    md_useD   = 1'b0;
    md_startE = 1'b0;
    md_divE   = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    cyc();
    check("reset_state", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    reset = 1'b0;
    cyc();

    // Load-use: lw $1 then addu reading $1 in E stage
    set_d(5'd1, 2'd3, 5'd29, 2'd1, 5'd0, 2'd3);
    check("lw_issue", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    set_d(5'd4, 2'd1, 5'd1, 2'd1, 5'd6, 2'd1);
    check("lw_use_stall", ev(1, 0, 0, 0, 0, 0, 0));
    cyc();
    check("lw_use_release", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    idle();
    check("lw_fwd_rsE_from_W", ev(0, 0, 0, 0, 2, 0, 0));
    cyc();
    drain();

    // ALU result feeding a branch compare in D
    set_d(5'd2, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
    cyc();
    set_d(5'd0, 2'd0, 5'd2, 2'd0, 5'd7, 2'd0);
    check("beq_stall", ev(1, 0, 0, 0, 0, 0, 0));
    cyc();
    check("beq_fwd_rsD_from_M", ev(0, 0, 1, 0, 0, 0, 0));
    cyc();
    drain();

    // $3 in both M and W; then only W; register 0 never hits
    set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    cyc();
    set_d(5'd3, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
    cyc();
    set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    cyc();
    set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd3, 2'd1);
    check("rtD_M_over_W", ev(0, 0, 0, 1, 0, 0, 0));
    cyc();
    set_d(5'd0, 2'd3, 5'd0, 2'd0, 5'd3, 2'd1);
    check("rtD_rtE_from_W_r0_not_fwd", ev(0, 0, 0, 2, 0, 2, 0));
    cyc();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    check("r0_never_stalls", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    drain();

    // sw store data: E-stage forward from M, then M-stage forward from W
    set_d(5'd5, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
    cyc();
    set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd5, 2'd2);
    check("sw_no_stall", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    idle();
    check("sw_fwd_rtE_from_M", ev(0, 0, 0, 0, 0, 1, 0));
    cyc();
    check("sw_fwd_rtM_from_W", ev(0, 0, 0, 0, 0, 0, 1));
    cyc();
    drain();

    // Flush wins over a simultaneous load-use stall
    set_d(5'd1, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    cyc();
    set_d(5'd4, 2'd1, 5'd1, 2'd1, 5'd0, 2'd3);
    flush = 1'b1;
    check("flush_with_stall", ev(1, 0, 0, 0, 0, 0, 0));
    cyc();
    flush = 1'b0;
    set_d(5'd4, 2'd1, 5'd1, 2'd0, 5'd0, 2'd3);
    check("flush_clears_entries", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    drain();

    // Divide then multiply with mflo waiting in D
    md_useD   = 1'b1;
    md_startE = 1'b1;
    md_divE   = 1'b1;
    check("div_start", ev(1, 1, 0, 0, 0, 0, 0));
    cyc();
    md_startE = 1'b0;
    md_divE   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("div_busy_%0d", i), ev(1, 1, 0, 0, 0, 0, 0));
      cyc();
    end
    check("div_done", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    md_startE = 1'b1;
    check("mult_start", ev(1, 1, 0, 0, 0, 0, 0));
    cyc();
    md_startE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mult_busy_%0d", i), ev(1, 1, 0, 0, 0, 0, 0));
      cyc();
    end
    check("mult_done", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    drain();

    // Asynchronous reset in the middle of a divide
    md_startE = 1'b1;
    md_divE   = 1'b1;
    check("div2_start_no_use", ev(0, 1, 0, 0, 0, 0, 0));
    cyc();
    md_startE = 1'b0;
    md_divE   = 1'b0;
    check("div2_busy", ev(0, 1, 0, 0, 0, 0, 0));
    cyc();
    cyc();
    reset = 1'b1;
    check("reset_mid_div_async", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    reset = 1'b0;
    check("after_reset_idle", ev(0, 0, 0, 0, 0, 0, 0));
    cyc();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
